m_ext_issue_ctrl: RTL and testbench
===================================

Name: m_ext_issue_ctrl

Overview:
Issue controller and writeback arbiter for the 5-stage M-extension pipeline. It sits between decode, the M pipeline and the single register-file write port.
- Forwards M instructions into stage M1 of the M pipeline.
- Keeps a destination scoreboard and stalls decode on RAW/WAW hazards against in-flight M ops.
- Arbitrates the RF write port between M5 results and main-pipeline writeback, using a 1-entry hold buffer.

Parameters:
M_DEPTH, 5, M pipeline latency issue→M5 (stages)
NUM_REGS, 32, architectural registers (addressed by REG_SIZE bits)

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
dec_valid_i  in  1  decode slot holds an instruction
dec_is_mext_i  in  1  instruction is M-extension
dec_opcode_i  in  m_ext_opcode_e  M opcode
dec_rs1_i / dec_rs2_i  in  REG_SIZE  source registers
dec_rd_i  in  REG_SIZE  destination register
dec_rf_we_i  in  1  instruction writes rd
dec_src_a_i / dec_src_b_i  in  WORD_SIZE  operands
dec_stall_o  out  1  hold decode this cycle
mp_valid_o  out  1  issue into M1
mp_opcode_o  out  m_ext_opcode_e  to M1
mp_src_a_o / mp_src_b_o  out  WORD_SIZE  to M1
mp_rf_waddr_o  out  REG_SIZE  to M1
mp_rf_we_o  out  1  to M1
mp_valid_m5_i  in  1  M5 result valid
mp_rf_we_i  in  1  M5 write enable
mp_rf_waddr_i  in  REG_SIZE  M5 destination
mp_rf_wdata_i  in  WORD_SIZE  M5 result
wb_valid_i / wb_rf_we_i  in  1  main-pipe writeback request
wb_rf_waddr_i  in  REG_SIZE  main-pipe destination
wb_rf_wdata_i  in  WORD_SIZE  main-pipe data
wb_stall_o  out  1  main-pipe writeback not accepted
rf_we_o  out  1  RF write enable
rf_waddr_o  out  REG_SIZE  RF write address
rf_wdata_o  out  WORD_SIZE  RF write data
inflight_o  out  3  M ops in flight (0..M_DEPTH)
busy_o  out  1  inflight_o != 0 or hold buffer full

Behaviour:
- Reset (asynchronous, rsn_i low):
  - Clears the pending bitmap, inflight counter and hold buffer immediately, without waiting for a clock edge.
  - All outputs read 0 while reset is low.
  - Applies mid-operation as well; in-flight M ops are discarded (the M pipeline shares rsn_i).
- Scoreboard:
  - pending[NUM_REGS] is registered.
  - Set on issue when rd != 0 and mp_rf_we_o = 1.
  - Cleared on mp_valid_m5_i & mp_rf_we_i for mp_rf_waddr_i.
  - If set and clear hit the same register in one cycle, set wins.
- Hazard detection, against the registered bitmap only (no bypass):
  - dec_stall_o = dec_valid_i & (pending[rs1]|pending[rs2]|(dec_rf_we_i & pending[rd])).
  - x0 never hazards.
  - This rule applies to both M and non-M instructions.
- Issue:
  - issue = dec_valid_i & dec_is_mext_i & !dec_stall_o.
  - mp_* outputs are combinational copies of the dec_* inputs gated by issue; latency 0.
  - Throughput is one issue per cycle, with no structural stall.
- Inflight counter:
  - +1 on issue, -1 on mp_valid_m5_i, unchanged when both occur in the same cycle.
  - Saturation cannot occur and is asserted.
- Writeback arbitration (M5 has absolute priority because it cannot stall):
  1. M5 valid → the RF write port takes the M5 result that cycle.
  2. Otherwise, hold buffer full → the port writes the hold entry, and the buffer empties at the edge.
  3. Otherwise, wb_valid_i → the port writes the main-pipe request directly.
- Capture into the hold buffer:
  - If M5 is valid, wb_valid_i is high and the hold buffer is empty, the WB request (we/addr/data) is captured at the edge.
- wb_stall_o = hold_full, combinational.
  - While it is high, wb_valid_i is ignored; upstream must keep its request.
  - M5 bursts keep the hold buffer full.
- RF writes to x0: rf_we_o is forced to 0. A hold entry with we=0 is still drained.
- Write ordering: the scoreboard guarantees the hold entry and an M5 result never target the same register, so ordering between them is irrelevant.

Decomposition:
- segre_pkg gains:
  - constant M_DEPTH
  - typedef rf_wreq_t {we, waddr, wdata}, used by the hold buffer and arbiter
- m_ext_opcode_e is reused from segre_pkg.
- One sub-module, m_ext_scoreboard: pending bitmap, set/clear, hazard compare, inflight counter.
- The arbiter and hold buffer stay in the top module.

Test Plan:
- MUL rd=x5 (a=6, b=7) issued cycle 0:
  - mp_valid_o=1 in cycle 0, pending[5]=1 in cycles 1..5.
  - M5 at cycle 5 gives rf_we_o=1, rf_waddr_o=5, rf_wdata_o=42; pending[5]=0 from cycle 6.
- ADD rs1=x5 presented in cycle 1 behind that MUL:
  - dec_stall_o=1 in cycles 1..5, 0 in cycle 6.
  - inflight_o goes 1 → 0 after cycle 5.
- Same-cycle conflict: M5 (x7, 0x10) with wb (x8, 0x20):
  - Cycle N: RF writes x7=0x10.
  - Cycle N+1: wb_stall_o=1, RF writes x8=0x20.
  - Cycle N+2: wb_stall_o=0.
- Five back-to-back M ops to x1..x5:
  - No dec_stall_o, inflight_o reaches 5.
  - Writebacks occur in consecutive cycles 5..9; an interleaved wb request stays held until cycle 10.
- M op with rd=x0: pending unchanged, inflight still counts it, rf_we_o=0 at M5.
- 3 ops in flight, rsn_i pulsed low mid-cycle:
  - pending, inflight_o, hold and all outputs read 0 immediately.
  - No writeback after release.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and constants for the M-extension issue/writeback slice.
//   WORD_SIZE / REG_SIZE / NUM_REGS : datapath and register-file geometry
//   M_DEPTH     : M pipeline latency from issue to M5 result
//   INFLIGHT_W  : width of the in-flight op counter (holds 0..M_DEPTH)
//   m_ext_opcode_e : M-extension operation selector
//   rf_wreq_t   : one register-file write request
`timescale 1ns/1ps
package segre_pkg;

  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned REG_SIZE   = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned M_DEPTH    = 5;
  localparam int unsigned INFLIGHT_W = 3;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_ext_opcode_e;

  typedef struct packed {
    logic                 we;
    logic [REG_SIZE-1:0]  waddr;
    logic [WORD_SIZE-1:0] wdata;
  } rf_wreq_t;

endpackage

// File: rtl/m_ext_scoreboard.sv
// Destination scoreboard for in-flight M ops.
//   dec_*        : decode slot being checked, and rd/we recorded on issue
//   issue_i      : decode slot enters M1 this cycle
//   retire_*     : M5 result (clears the pending bit of its destination)
//   hazard_o     : RAW/WAW hazard against the registered pending bitmap
//   inflight_o   : number of M ops between issue and M5
`timescale 1ns/1ps
module m_ext_scoreboard
  import segre_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  dec_valid_i,
  input  logic [REG_SIZE-1:0]   dec_rs1_i,
  input  logic [REG_SIZE-1:0]   dec_rs2_i,
  input  logic [REG_SIZE-1:0]   dec_rd_i,
  input  logic                  dec_rf_we_i,
  input  logic                  issue_i,
  input  logic                  retire_i,
  input  logic                  retire_we_i,
  input  logic [REG_SIZE-1:0]   retire_waddr_i,
  output logic                  hazard_o,
  output logic [INFLIGHT_W-1:0] inflight_o
);

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;

  // Bit 0 is never set, so x0 can never raise a hazard.
  assign hazard_o = dec_valid_i &
                    (pending_q[dec_rs1_i] | pending_q[dec_rs2_i] |
                     (dec_rf_we_i & pending_q[dec_rd_i]));

  assign inflight_o = inflight_q;

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (retire_i && retire_we_i) begin
      pending_d[retire_waddr_i] = 1'b0;
    end
    if (issue_i && dec_rf_we_i && (dec_rd_i != '0)) begin
      pending_d[dec_rd_i] = 1'b1;
    end
  end

  // Issue and retire in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue_i, retire_i})
      2'b10:   inflight_d = inflight_q + INFLIGHT_W'(1);
      2'b01:   inflight_d = inflight_q - INFLIGHT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      // The M pipeline holds at most M_DEPTH ops and never retires from empty.
      assert (!(issue_i && !retire_i && (inflight_q == INFLIGHT_W'(M_DEPTH))));
      assert (!(retire_i && !issue_i && (inflight_q == '0)));
    end
  end

endmodule

// File: rtl/m_ext_issue_ctrl.sv
// Issue controller and RF writeback arbiter for the M-extension pipeline.
//   clk_i, rsn_i      : clock, async active-low reset (all outputs 0 while low)
//   dec_*             : decode slot; dec_stall_o holds it on a hazard
//   mp_* (out)        : combinational issue into M1
//   mp_*_i (in)       : M5 result, always has RF port priority
//   wb_*              : main-pipe writeback; wb_stall_o while hold buffer full
//   rf_*              : single register-file write port
//   inflight_o/busy_o : status
`timescale 1ns/1ps
module m_ext_issue_ctrl
  import segre_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  dec_valid_i,
  input  logic                  dec_is_mext_i,
  input  m_ext_opcode_e         dec_opcode_i,
  input  logic [REG_SIZE-1:0]   dec_rs1_i,
  input  logic [REG_SIZE-1:0]   dec_rs2_i,
  input  logic [REG_SIZE-1:0]   dec_rd_i,
  input  logic                  dec_rf_we_i,
  input  logic [WORD_SIZE-1:0]  dec_src_a_i,
  input  logic [WORD_SIZE-1:0]  dec_src_b_i,
  output logic                  dec_stall_o,
  output logic                  mp_valid_o,
  output m_ext_opcode_e         mp_opcode_o,
  output logic [WORD_SIZE-1:0]  mp_src_a_o,
  output logic [WORD_SIZE-1:0]  mp_src_b_o,
  output logic [REG_SIZE-1:0]   mp_rf_waddr_o,
  output logic                  mp_rf_we_o,
  input  logic                  mp_valid_m5_i,
  input  logic                  mp_rf_we_i,
  input  logic [REG_SIZE-1:0]   mp_rf_waddr_i,
  input  logic [WORD_SIZE-1:0]  mp_rf_wdata_i,
  input  logic                  wb_valid_i,
  input  logic                  wb_rf_we_i,
  input  logic [REG_SIZE-1:0]   wb_rf_waddr_i,
  input  logic [WORD_SIZE-1:0]  wb_rf_wdata_i,
  output logic                  wb_stall_o,
  output logic                  rf_we_o,
  output logic [REG_SIZE-1:0]   rf_waddr_o,
  output logic [WORD_SIZE-1:0]  rf_wdata_o,
  output logic [INFLIGHT_W-1:0] inflight_o,
  output logic                  busy_o
);

  logic                  hazard;
  logic                  issue;
  logic [INFLIGHT_W-1:0] inflight;

  rf_wreq_t hold_q, hold_d;
  logic     hold_full_q, hold_full_d;
  rf_wreq_t m5_req, wb_req, sel_req;
  logic     sel_valid;

  // rsn_i gates every combinational output so they read 0 during reset.
  assign issue = rsn_i & dec_valid_i & dec_is_mext_i & ~hazard;

  m_ext_scoreboard u_scoreboard (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .dec_valid_i    (dec_valid_i),
    .dec_rs1_i      (dec_rs1_i),
    .dec_rs2_i      (dec_rs2_i),
    .dec_rd_i       (dec_rd_i),
    .dec_rf_we_i    (dec_rf_we_i),
    .issue_i        (issue),
    .retire_i       (mp_valid_m5_i),
    .retire_we_i    (mp_rf_we_i),
    .retire_waddr_i (mp_rf_waddr_i),
    .hazard_o       (hazard),
    .inflight_o     (inflight)
  );

  assign dec_stall_o   = rsn_i & hazard;
  assign mp_valid_o    = issue;
  assign mp_opcode_o   = issue ? dec_opcode_i : M_MUL;
  assign mp_src_a_o    = issue ? dec_src_a_i : '0;
  assign mp_src_b_o    = issue ? dec_src_b_i : '0;
  assign mp_rf_waddr_o = issue ? dec_rd_i : '0;
  assign mp_rf_we_o    = issue & dec_rf_we_i;

  // Port priority: M5, then hold entry, then direct WB. A WB request that
  // collides with M5 is parked in the hold buffer when it is free.
  always_comb begin
    m5_req      = '{we: mp_rf_we_i, waddr: mp_rf_waddr_i, wdata: mp_rf_wdata_i};
    wb_req      = '{we: wb_rf_we_i, waddr: wb_rf_waddr_i, wdata: wb_rf_wdata_i};
    sel_valid   = 1'b0;
    sel_req     = '0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (mp_valid_m5_i) begin
      sel_valid = 1'b1;
      sel_req   = m5_req;
      if (!hold_full_q && wb_valid_i) begin
        hold_full_d = 1'b1;
        hold_d      = wb_req;
      end
    end else if (hold_full_q) begin
      sel_valid   = 1'b1;
      sel_req     = hold_q;
      hold_full_d = 1'b0;
    end else if (wb_valid_i) begin
      sel_valid = 1'b1;
      sel_req   = wb_req;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Writes to x0 are suppressed, but the request still occupies the port.
  assign rf_we_o    = rsn_i & sel_valid & sel_req.we & (sel_req.waddr != '0);
  assign rf_waddr_o = (rsn_i & sel_valid) ? sel_req.waddr : '0;
  assign rf_wdata_o = (rsn_i & sel_valid) ? sel_req.wdata : '0;

  assign wb_stall_o = rsn_i & hold_full_q;
  assign inflight_o = rsn_i ? inflight : '0;
  assign busy_o     = rsn_i & ((inflight != '0) | hold_full_q);

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
`timescale 1ns/1ps
module tb_m_ext_issue_ctrl;
  import segre_pkg::*;

  logic clk_i = 1'b0;
  logic rsn_i;
  logic dec_valid_i, dec_is_mext_i, dec_rf_we_i;
  m_ext_opcode_e dec_opcode_i;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic [31:0] dec_src_a_i, dec_src_b_i;
  logic dec_stall_o, mp_valid_o, mp_rf_we_o;
  m_ext_opcode_e mp_opcode_o;
  logic [31:0] mp_src_a_o, mp_src_b_o;
  logic [4:0]  mp_rf_waddr_o;
  logic mp_valid_m5_i, mp_rf_we_i;
  logic [4:0]  mp_rf_waddr_i;
  logic [31:0] mp_rf_wdata_i;
  logic wb_valid_i, wb_rf_we_i;
  logic [4:0]  wb_rf_waddr_i;
  logic [31:0] wb_rf_wdata_i;
  logic wb_stall_o, rf_we_o, busy_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [2:0]  inflight_o;

  always #5 clk_i = ~clk_i;

  m_ext_issue_ctrl dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .dec_valid_i(dec_valid_i), .dec_is_mext_i(dec_is_mext_i), .dec_opcode_i(dec_opcode_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i), .dec_rf_we_i(dec_rf_we_i),
    .dec_src_a_i(dec_src_a_i), .dec_src_b_i(dec_src_b_i), .dec_stall_o(dec_stall_o),
    .mp_valid_o(mp_valid_o), .mp_opcode_o(mp_opcode_o), .mp_src_a_o(mp_src_a_o),
    .mp_src_b_o(mp_src_b_o), .mp_rf_waddr_o(mp_rf_waddr_o), .mp_rf_we_o(mp_rf_we_o),
    .mp_valid_m5_i(mp_valid_m5_i), .mp_rf_we_i(mp_rf_we_i), .mp_rf_waddr_i(mp_rf_waddr_i),
    .mp_rf_wdata_i(mp_rf_wdata_i), .wb_valid_i(wb_valid_i), .wb_rf_we_i(wb_rf_we_i),
    .wb_rf_waddr_i(wb_rf_waddr_i), .wb_rf_wdata_i(wb_rf_wdata_i), .wb_stall_o(wb_stall_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .inflight_o(inflight_o), .busy_o(busy_o)
  );

  // Stand-in M pipeline: 5 stages, result = src_a * src_b.
  logic [4:0]  pv, pw;
  logic [4:0]  pa [5];
  logic [31:0] pd [5];
  always @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pv <= '0;
      pw <= '0;
      for (int i = 0; i < 5; i++) begin
        pa[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      pv    <= {pv[3:0], mp_valid_o};
      pw    <= {pw[3:0], mp_rf_we_o};
      pa[0] <= mp_rf_waddr_o;
      pd[0] <= mp_src_a_o * mp_src_b_o;
      for (int i = 1; i < 5; i++) begin
        pa[i] <= pa[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign mp_valid_m5_i = pv[4];
  assign mp_rf_we_i    = pw[4];
  assign mp_rf_waddr_i = pa[4];
  assign mp_rf_wdata_i = pd[4];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          c;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_wr(input int c, input int a, input int d);
    exp_t e;
    e.c    = c;
    e.addr = 5'(a);
    e.data = 32'(d);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every RF write must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rsn_i && rf_we_o) begin
      if (exp_q.size() == 0) begin
        chk("rf_unexpected_write", 32'(rf_waddr_o), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_cycle", 32'(cyc), 32'(mon_e.c));
        chk("rf_waddr", 32'(rf_waddr_o), 32'(mon_e.addr));
        chk("rf_wdata", rf_wdata_o, mon_e.data);
      end
    end
  end

  task automatic idle();
    dec_valid_i = 0; dec_is_mext_i = 0; dec_opcode_i = M_MUL;
    dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0; dec_rf_we_i = 0;
    dec_src_a_i = 0; dec_src_b_i = 0;
    wb_valid_i = 0; wb_rf_we_i = 0; wb_rf_waddr_i = 0; wb_rf_wdata_i = 0;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic mul(input int rd, input int a, input int b, input int rs1);
    dec_valid_i = 1; dec_is_mext_i = 1; dec_opcode_i = M_MUL;
    dec_rs1_i = 5'(rs1); dec_rs2_i = 0; dec_rd_i = 5'(rd); dec_rf_we_i = 1;
    dec_src_a_i = 32'(a); dec_src_b_i = 32'(b);
  endtask

  task automatic wb(input int rd, input int d);
    wb_valid_i = 1; wb_rf_we_i = 1; wb_rf_waddr_i = 5'(rd); wb_rf_wdata_i = 32'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c0;
  initial begin
    rsn_i = 0;
    idle();
    mul(3, 2, 2, 0);
    wb(4, 1);
    #2;
    chk("rst_mp_valid", 32'(mp_valid_o), 0);
    chk("rst_rf_we", 32'(rf_we_o), 0);
    chk("rst_inflight", 32'(inflight_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_wb_stall", 32'(wb_stall_o), 0);
    chk("rst_dec_stall", 32'(dec_stall_o), 0);
    idle();
    @(posedge clk_i); #3 rsn_i = 1;

    // MUL x5 = 6*7, then a dependent ADD behind it.
    next(); c0 = cyc;
    mul(5, 6, 7, 0);
    expect_wr(c0 + 5, 5, 42);
    smp();
    chk("mul_mp_valid", 32'(mp_valid_o), 1);
    chk("mul_mp_src_a", mp_src_a_o, 6);
    chk("mul_mp_src_b", mp_src_b_o, 7);
    chk("mul_mp_waddr", 32'(mp_rf_waddr_o), 5);
    chk("mul_mp_opcode", 32'(mp_opcode_o), 32'(M_MUL));
    chk("mul_dec_stall", 32'(dec_stall_o), 0);
    for (int k = 1; k <= 6; k++) begin
      next();
      idle();
      dec_valid_i = 1; dec_rs1_i = 5; dec_rd_i = 6; dec_rf_we_i = 1;
      smp();
      chk($sformatf("raw_stall_k%0d", k), 32'(dec_stall_o), (k <= 5) ? 1 : 0);
      chk($sformatf("raw_mp_valid_k%0d", k), 32'(mp_valid_o), 0);
      if (k == 1) chk("raw_inflight_1", 32'(inflight_o), 1);
      if (k == 6) chk("raw_inflight_0", 32'(inflight_o), 0);
    end

    // M5 x7=0x10 collides with WB x8=0x20; then direct WB and WB to x0.
    next(); c0 = cyc;
    idle(); mul(7, 4, 4, 0);
    expect_wr(c0 + 5, 7, 32'h10);
    for (int k = 1; k <= 10; k++) begin
      next();
      idle();
      if (k == 5) begin wb(8, 32'h20); expect_wr(c0 + 6, 8, 32'h20); end
      if (k == 8) begin wb(9, 32'h33); expect_wr(c0 + 8, 9, 32'h33); end
      if (k == 9) wb(0, 32'h44);
      smp();
      if (k == 5) chk("cf_wb_stall_n", 32'(wb_stall_o), 0);
      if (k == 6) chk("cf_wb_stall_n1", 32'(wb_stall_o), 1);
      if (k == 6) chk("cf_busy_n1", 32'(busy_o), 1);
      if (k == 7) chk("cf_wb_stall_n2", 32'(wb_stall_o), 0);
      if (k == 7) chk("cf_busy_n2", 32'(busy_o), 0);
      if (k == 9) chk("wb_x0_we", 32'(rf_we_o), 0);
    end

    // Five back-to-back MULs to x1..x5, WB x20 interleaved at first M5.
    for (int i = 0; i < 5; i++) begin
      next();
      if (i == 0) c0 = cyc;
      idle(); mul(i + 1, i + 2, 3, 0);
      expect_wr(c0 + 5 + i, i + 1, 3 * (i + 2));
      smp();
      chk($sformatf("b2b_stall_%0d", i), 32'(dec_stall_o), 0);
      chk($sformatf("b2b_inflight_%0d", i), 32'(inflight_o), 32'(i));
    end
    next();
    idle(); wb(20, 32'hABCD);
    expect_wr(c0 + 10, 20, 32'hABCD);
    smp();
    chk("b2b_inflight_5", 32'(inflight_o), 5);
    chk("b2b_wb_stall_5", 32'(wb_stall_o), 0);
    for (int k = 6; k <= 11; k++) begin
      next();
      idle();
      smp();
      chk($sformatf("b2b_wb_stall_%0d", k), 32'(wb_stall_o), (k <= 10) ? 1 : 0);
    end
    chk("b2b_inflight_end", 32'(inflight_o), 0);

    // MUL to x0: counted in flight, no pending bit, no RF write.
    next(); c0 = cyc;
    idle(); mul(0, 9, 9, 0);
    smp();
    chk("x0_mp_valid", 32'(mp_valid_o), 1);
    for (int k = 1; k <= 6; k++) begin
      next();
      idle();
      dec_valid_i = 1; dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0; dec_rf_we_i = 1;
      smp();
      if (k == 1) chk("x0_inflight", 32'(inflight_o), 1);
      if (k == 1) chk("x0_no_stall", 32'(dec_stall_o), 0);
      if (k == 5) chk("x0_rf_we", 32'(rf_we_o), 0);
      if (k == 6) chk("x0_inflight_end", 32'(inflight_o), 0);
    end

    // Three ops in flight, then reset pulsed mid-cycle.
    for (int i = 0; i < 3; i++) begin
      next();
      idle(); mul(10 + i, 1, i, 0);
    end
    next();
    idle(); mul(13, 1, 1, 10);
    #1;
    chk("mid_stall_pre", 32'(dec_stall_o), 1);
    chk("mid_inflight_pre", 32'(inflight_o), 3);
    chk("mid_busy_pre", 32'(busy_o), 1);
    #1 rsn_i = 0;
    #1;
    chk("mid_inflight_rst", 32'(inflight_o), 0);
    chk("mid_busy_rst", 32'(busy_o), 0);
    chk("mid_stall_rst", 32'(dec_stall_o), 0);
    chk("mid_mp_valid_rst", 32'(mp_valid_o), 0);
    chk("mid_rf_we_rst", 32'(rf_we_o), 0);
    idle();
    @(posedge clk_i); #3 rsn_i = 1;
    next();
    chk("post_rst_stall", 32'(dec_stall_o), 0);
    repeat (10) next();
    chk("exp_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
